pe_mac_unit: RTL and testbench
==============================

PE_MAC_UNIT -- requirements
Module: pe_mac_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width in bits.
REQ-002 SHALL have parameter ACC_W, default 64, accumulator width in bits; ACC_W >= 2*DATA_W.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 pe_active  in  1  controller enable; new steps start only while high.
REQ-006 vec_fin  in  1  controller pulse: vector complete; write result and clear accumulator.
REQ-007 N  in  32  vector length; sampled at the start of each vector.
REQ-008 left_mem_index / right_mem_index / result_mem_index  in  32 each  addresses from controller.
REQ-009 step_fin  out  1  one-cycle pulse per completed step (MAC or flush).
REQ-010 left_rd_en, right_rd_en  out  1 each  operand read strobes.
REQ-011 left_rd_addr, right_rd_addr  out  32 each  operand read addresses.
REQ-012 left_rd_data, right_rd_data  in  DATA_W each  signed operands, valid exactly one cycle after rd_en.
REQ-013 res_wr_en  out  1; res_wr_addr  out  32; res_wr_data  out  DATA_W  result write port.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 seq_err  out  1  sticky: vec_fin protocol violation.

Function
REQ-016 SHALL implement states IDLE, FETCH, WAIT, MAC, FLUSH, SETTLE.
REQ-017 IDLE: if pe_active, go to FETCH when k < N_lat, else to FLUSH; otherwise stay. k = MAC count in the current vector (32-bit); N_lat = latched N.
REQ-018 N_lat and res_addr_lat (result_mem_index) SHALL be latched on leaving IDLE or SETTLE when k == 0.
REQ-019 FETCH (1 cycle): left/right_rd_en = 1; rd_addr = current left/right_mem_index; next WAIT.
REQ-020 WAIT (1 cycle): next MAC.
REQ-021 MAC (1 cycle): acc <= acc + sign-extended product left_rd_data*right_rd_data (full 2*DATA_W product, modulo 2^ACC_W); k <= k+1; step_fin = 1; next SETTLE.
REQ-022 FLUSH (1 cycle): no read, no accumulate; step_fin = 1; next SETTLE.
REQ-023 SETTLE (1 cycle, controller indices now updated): if previous state was FLUSH and vec_fin = 1: res_wr_en = 1, res_wr_addr = res_addr_lat, res_wr_data = acc[DATA_W-1:0]; acc <= 0; k <= 0.
REQ-024 SETTLE exit: to FETCH if pe_active and k' < N_lat; to FLUSH if pe_active and k' == N_lat; else IDLE (k' = k after this cycle's update).
REQ-025 Step latency: FETCH to step_fin = 2 cycles; full MAC step = 4 cycles; flush step = 2 cycles.
REQ-026 Write data SHALL truncate acc to DATA_W bits (two's-complement wrap, no saturation).
REQ-027 N_lat == 0: vector is a single flush; written result = 0.
REQ-028 vec_fin outside SETTLE SHALL be ignored; vec_fin in SETTLE after MAC SHALL set seq_err and not write.
REQ-029 Missing vec_fin in SETTLE after FLUSH SHALL set seq_err; acc and k kept; next step re-enters FLUSH.
REQ-030 pe_active falling mid-step: current step completes through SETTLE; then IDLE with acc, k, latches held; resumes on re-assertion.
REQ-031 step_fin, rd_en, res_wr_en SHALL be decoded from registered state only (no input-to-output combinational paths except rd_addr and SETTLE write gating by vec_fin).

Reset
REQ-032 rst high SHALL immediately force IDLE, acc = 0, k = 0, N_lat = 0, res_addr_lat = 0, seq_err = 0.
REQ-033 During and after reset, all outputs SHALL be 0 until the first post-reset transition.
REQ-034 Reset mid-step SHALL abandon the step without a write; a read returning later SHALL be ignored.

Verification
REQ-035 N=3, operands (2,3),(4,5),(-1,7), vec_fin in SETTLE after flush -> one write, data 19, addr = result_mem_index at vector start; 4 step_fin pulses.
REQ-036 left=0x7FFFFFFF, right=0x7FFFFFFF, N=2 -> res_wr_data = 0x00000002 (low 32 bits of 2*(2^31-1)^2).
REQ-037 N=0, pe_active high -> FLUSH then SETTLE with vec_fin -> write data 0, no rd_en ever.
REQ-038 Flush step with vec_fin withheld -> seq_err = 1, no write, acc retained; next step is FLUSH again.
REQ-039 pe_active dropped during WAIT -> MAC still completes, step_fin once, IDLE; re-assert -> FETCH with k continuing.
REQ-040 rst asserted in WAIT of step 2 of N=4 -> outputs 0 same cycle; after release, new vector starts from acc = 0, k = 0.

Source files
------------

// File: rtl/pe_mac_unit_if.sv
// Controller, operand-read and result-write signals of the MAC processing element.
// The PE side uses the master modport; the controller/memory side uses slave.
interface pe_mac_unit_if #(
   parameter int DATA_W = 32
);
   logic              pe_active;
   logic              vec_fin;
   logic [31:0]       N;
   logic [31:0]       left_mem_index;
   logic [31:0]       right_mem_index;
   logic [31:0]       result_mem_index;
   logic              step_fin;
   logic              left_rd_en;
   logic              right_rd_en;
   logic [31:0]       left_rd_addr;
   logic [31:0]       right_rd_addr;
   logic [DATA_W-1:0] left_rd_data;
   logic [DATA_W-1:0] right_rd_data;
   logic              res_wr_en;
   logic [31:0]       res_wr_addr;
   logic [DATA_W-1:0] res_wr_data;
   logic              busy;
   logic              seq_err;

   modport master (
      input  pe_active, vec_fin, N, left_mem_index, right_mem_index, result_mem_index,
      input  left_rd_data, right_rd_data,
      output step_fin, left_rd_en, right_rd_en, left_rd_addr, right_rd_addr,
      output res_wr_en, res_wr_addr, res_wr_data, busy, seq_err
   );

   modport slave (
      output pe_active, vec_fin, N, left_mem_index, right_mem_index, result_mem_index,
      output left_rd_data, right_rd_data,
      input  step_fin, left_rd_en, right_rd_en, left_rd_addr, right_rd_addr,
      input  res_wr_en, res_wr_addr, res_wr_data, busy, seq_err
   );
endinterface

// File: rtl/pe_mac_unit.sv
// Multiply-accumulate processing element: one MAC per 4-cycle step, a flush step per
// vector that writes the truncated accumulator when the controller confirms with vec_fin.
module pe_mac_unit #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 64
) (
   input logic           clk,
   input logic           rst,
   pe_mac_unit_if.master bus
);
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_MAC    = 3'd3,
      ST_FLUSH  = 3'd4,
      ST_SETTLE = 3'd5
   } state_t;

   state_t                    state_r;
   state_t                    state_nxt_s;
   logic                      from_flush_r;
   logic [ACC_W-1:0]          acc_r;
   logic [ACC_W-1:0]          acc_nxt_s;
   logic [31:0]               k_r;
   logic [31:0]               k_nxt_s;
   logic [31:0]               n_lat_r;
   logic [31:0]               res_addr_lat_r;
   logic [31:0]               n_cmp_s;
   logic                      seq_err_r;
   logic                      seq_err_nxt_s;
   logic                      wr_s;
   logic                      start_s;
   logic                      latch_s;
   logic signed [DATA_W-1:0]  left_op_r;
   logic signed [DATA_W-1:0]  right_op_r;
   logic signed [2*DATA_W-1:0] prod_s;
   logic [ACC_W-1:0]          prod_ext_s;

   assign prod_s     = (2*DATA_W)'(left_op_r) * (2*DATA_W)'(right_op_r);
   assign prod_ext_s = ACC_W'(prod_s);

   // Accumulator, step counter, write gating and sequence-error detection
   always_comb begin
      acc_nxt_s     = acc_r;
      k_nxt_s       = k_r;
      seq_err_nxt_s = seq_err_r;
      wr_s          = 1'b0;
      case (state_r)
         ST_MAC: begin
            acc_nxt_s = acc_r + prod_ext_s;
            k_nxt_s   = k_r + 32'd1;
         end
         ST_SETTLE: begin
            if (from_flush_r) begin
               if (bus.vec_fin) begin
                  wr_s      = 1'b1;
                  acc_nxt_s = {ACC_W{1'b0}};
                  k_nxt_s   = 32'd0;
               end else begin
                  seq_err_nxt_s = 1'b1;
               end
            end else begin
               if (bus.vec_fin) begin
                  seq_err_nxt_s = 1'b1;
               end else begin
                  seq_err_nxt_s = seq_err_r;
               end
            end
         end
         default: begin
            acc_nxt_s = acc_r;
         end
      endcase
   end

   // Next-state decode; a vector starting afresh (k == 0) compares against the live N
   always_comb begin
      n_cmp_s     = (k_nxt_s == 32'd0) ? bus.N : n_lat_r;
      state_nxt_s = state_r;
      start_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.pe_active) begin
               start_s     = 1'b1;
               state_nxt_s = (k_nxt_s < n_cmp_s) ? ST_FETCH : ST_FLUSH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: state_nxt_s = ST_WAIT;
         ST_WAIT:  state_nxt_s = ST_MAC;
         ST_MAC:   state_nxt_s = ST_SETTLE;
         ST_FLUSH: state_nxt_s = ST_SETTLE;
         ST_SETTLE: begin
            if (bus.pe_active && (k_nxt_s < n_cmp_s)) begin
               start_s     = 1'b1;
               state_nxt_s = ST_FETCH;
            end else if (bus.pe_active && (k_nxt_s == n_cmp_s)) begin
               start_s     = 1'b1;
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
      latch_s = start_s && (k_nxt_s == 32'd0);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         from_flush_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         from_flush_r <= (state_r == ST_FLUSH);
      end
   end

   // Datapath registers; operands are captured in WAIT, the cycle the read data is valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r          <= {ACC_W{1'b0}};
         k_r            <= 32'd0;
         seq_err_r      <= 1'b0;
         n_lat_r        <= 32'd0;
         res_addr_lat_r <= 32'd0;
         left_op_r      <= {DATA_W{1'b0}};
         right_op_r     <= {DATA_W{1'b0}};
      end else begin
         acc_r     <= acc_nxt_s;
         k_r       <= k_nxt_s;
         seq_err_r <= seq_err_nxt_s;
         if (latch_s) begin
            n_lat_r        <= bus.N;
            res_addr_lat_r <= bus.result_mem_index;
         end
         if (state_r == ST_WAIT) begin
            left_op_r  <= bus.left_rd_data;
            right_op_r <= bus.right_rd_data;
         end
      end
   end

   assign bus.step_fin      = (state_r == ST_MAC) || (state_r == ST_FLUSH);
   assign bus.left_rd_en    = (state_r == ST_FETCH);
   assign bus.right_rd_en   = (state_r == ST_FETCH);
   assign bus.left_rd_addr  = (state_r == ST_FETCH) ? bus.left_mem_index : 32'd0;
   assign bus.right_rd_addr = (state_r == ST_FETCH) ? bus.right_mem_index : 32'd0;
   assign bus.res_wr_en     = wr_s;
   assign bus.res_wr_addr   = wr_s ? res_addr_lat_r : 32'd0;
   assign bus.res_wr_data   = wr_s ? acc_r[DATA_W-1:0] : {DATA_W{1'b0}};
   assign bus.busy          = (state_r != ST_IDLE);
   assign bus.seq_err       = seq_err_r;
endmodule

// File: tb/tb_pe_mac_unit.sv
// Directed bench for pe_mac_unit: a task-driven controller/memory model issues vectors,
// expected writes go to a queue and a negedge monitor checks every result write.
module tb_pe_mac_unit;
   localparam logic [31:0] POISON = 32'hA5A5_5A5A;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pe_mac_unit_if #(.DATA_W(32)) bus ();
   pe_mac_unit #(.DATA_W(32), .ACC_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

   int          checks = 0;
   int          fails  = 0;
   wr_t         sb_q[$];
   wr_t         got_w;
   wr_t         exp_w;
   logic [31:0] lmem [0:15];
   logic [31:0] rmem [0:15];
   int          sf_total = 0;
   int          rd_total = 0;
   logic        sf_prev  = 1'b0;
   logic        rd_prev  = 1'b0;
   logic [31:0] laddr_prev = 32'd0;
   logic [31:0] raddr_prev = 32'd0;

   always @(negedge clk) begin
      if (bus.res_wr_en === 1'b1) begin
         checks++;
         got_w = {bus.res_wr_addr, bus.res_wr_data};
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL wr_unexpected: got addr=%0h data=%0h, required no write", got_w.addr, got_w.data);
         end else begin
            exp_w = sb_q.pop_front();
            if (got_w !== exp_w) begin
               fails++;
               $display("FAIL wr: got addr=%0h data=%0h, required addr=%0h data=%0h",
                        got_w.addr, got_w.data, exp_w.addr, exp_w.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string name);
      chk({name, "_ctl"}, {58'd0, bus.busy, bus.step_fin, bus.left_rd_en, bus.right_rd_en,
                           bus.res_wr_en, bus.seq_err}, 64'd0);
      chk({name, "_bus"}, {32'd0, bus.left_rd_addr | bus.right_rd_addr | bus.res_wr_addr | bus.res_wr_data}, 64'd0);
   endtask

   // One clock: sample outputs at negedge, then drive memory response just after posedge
   task automatic tick();
      @(negedge clk);
      sf_prev    = bus.step_fin;
      rd_prev    = bus.left_rd_en;
      laddr_prev = bus.left_rd_addr;
      raddr_prev = bus.right_rd_addr;
      if (sf_prev) sf_total++;
      if (rd_prev) rd_total++;
      @(posedge clk);
      #1;
      bus.left_rd_data  = rd_prev ? lmem[laddr_prev[3:0]] : POISON;
      bus.right_rd_data = rd_prev ? rmem[raddr_prev[3:0]] : POISON;
   endtask

   task automatic run_vector(input logic [31:0] n, input logic [31:0] lbase, input logic [31:0] rbase,
                             input logic [31:0] raddr, input logic [31:0] exp_data, input int skips,
                             input int pause_step, input logic stray, output int steps, output int rds);
      int macs = 0;
      int skip_left = skips;
      int paused = 0;
      int cyc = 0;
      int base;
      logic done = 1'b0;
      steps = 0;
      rds   = 0;
      sb_q.push_back({raddr, exp_data});
      bus.N                = n;
      bus.left_mem_index   = lbase;
      bus.right_mem_index  = rbase;
      bus.result_mem_index = raddr;
      bus.vec_fin          = 1'b0;
      bus.pe_active        = 1'b1;
      while (!done && cyc < 200) begin
         tick();
         cyc++;
         bus.vec_fin          = 1'b0;
         bus.N                = 32'd7;
         bus.result_mem_index = raddr + 32'd64;
         if (sf_prev) begin
            steps++;
            if (macs < int'(n)) begin
               macs++;
               bus.left_mem_index++;
               bus.right_mem_index++;
               if (stray) bus.vec_fin = 1'b1;
               if (paused == 1) begin
                  base = sf_total;
                  repeat (3) tick();
                  chk("pause_idle_busy", {63'd0, bus.busy}, 64'd0);
                  chk("pause_no_step", 64'(sf_total - base), 64'd0);
                  bus.pe_active = 1'b1;
                  paused = 2;
               end
            end else if (skip_left > 0) begin
               skip_left--;
            end else begin
               bus.vec_fin   = 1'b1;
               bus.pe_active = 1'b0;
               tick();
               bus.vec_fin = 1'b0;
               done = 1'b1;
            end
         end else if (rd_prev) begin
            rds++;
            if (stray) bus.vec_fin = 1'b1;
            if (pause_step == macs + 1 && paused == 0) begin
               bus.pe_active = 1'b0;
               paused = 1;
            end
         end
      end
      chk("vec_done", {63'd0, done}, 64'd1);
   endtask

   initial begin
      int st;
      int rd;
      int start;
      int cyc;
      rst                  = 1'b1;
      bus.pe_active        = 1'b0;
      bus.vec_fin          = 1'b0;
      bus.N                = 32'd0;
      bus.left_mem_index   = 32'd0;
      bus.right_mem_index  = 32'd0;
      bus.result_mem_index = 32'd0;
      bus.left_rd_data     = POISON;
      bus.right_rd_data    = POISON;
      for (int i = 0; i < 16; i++) begin
         lmem[i] = POISON;
         rmem[i] = POISON;
      end
      lmem[0] = 32'd2;          rmem[0] = 32'd3;
      lmem[1] = 32'd4;          rmem[1] = 32'd5;
      lmem[2] = 32'hFFFF_FFFF;  rmem[2] = 32'd7;
      lmem[3] = 32'h7FFF_FFFF;  rmem[3] = 32'h7FFF_FFFF;
      lmem[4] = 32'h7FFF_FFFF;  rmem[4] = 32'h7FFF_FFFF;
      lmem[5] = 32'hFFFF_FFFD;  rmem[9] = 32'd5;
      lmem[6] = 32'd2;          rmem[10] = 32'hFFFF_FFFC;
      lmem[7] = 32'd6;          rmem[7] = 32'd7;
      for (int i = 0; i < 4; i++) begin
         lmem[8 + i]  = 32'(i + 1);
         rmem[11 + i] = 32'd10;
      end

      repeat (2) @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // Basic dot product and result-address latch
      run_vector(32'd3, 32'd0, 32'd0, 32'd5, 32'd19, 0, 0, 1'b0, st, rd);
      chk("t1_steps", 64'(st), 64'd4);
      chk("t1_reads", 64'(rd), 64'd3);
      // Accumulator wider than the write port: low word of 2*(2^31-1)^2
      run_vector(32'd2, 32'd3, 32'd3, 32'd6, 32'h0000_0002, 0, 0, 1'b0, st, rd);
      // Empty vector: single flush, zero result, no reads
      run_vector(32'd0, 32'd0, 32'd0, 32'd7, 32'd0, 0, 0, 1'b0, st, rd);
      chk("t3_steps", 64'(st), 64'd1);
      chk("t3_reads", 64'(rd), 64'd0);
      // Signed operands, distinct left/right bases, negative result
      run_vector(32'd2, 32'd5, 32'd9, 32'd8, 32'hFFFF_FFE9, 0, 0, 1'b0, st, rd);
      chk("t4_seq_err", {63'd0, bus.seq_err}, 64'd0);
      // Withheld vec_fin on the first flush
      run_vector(32'd1, 32'd7, 32'd7, 32'd9, 32'd42, 1, 0, 1'b0, st, rd);
      chk("t5_seq_err", {63'd0, bus.seq_err}, 64'd1);
      chk("t5_steps", 64'(st), 64'd3);
      chk("t5_reads", 64'(rd), 64'd1);

      // Reset in WAIT of step 2 of an N=4 vector
      start = rd_total;
      cyc = 0;
      bus.N                = 32'd4;
      bus.left_mem_index   = 32'd8;
      bus.right_mem_index  = 32'd11;
      bus.result_mem_index = 32'd13;
      bus.pe_active        = 1'b1;
      while (!(rd_prev && (rd_total - start) == 2) && cyc < 100) begin
         tick();
         cyc++;
         if (sf_prev) begin
            bus.left_mem_index++;
            bus.right_mem_index++;
         end
      end
      chk("t6_reached_wait", 64'(rd_total - start), 64'd2);
      rst = 1'b1;
      #1;
      chk_outputs_zero("t6_reset");
      bus.pe_active = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      run_vector(32'd2, 32'd8, 32'd11, 32'd10, 32'd30, 0, 0, 1'b0, st, rd);
      chk("t6_seq_err", {63'd0, bus.seq_err}, 64'd0);

      // pe_active dropped in WAIT of step 2, resumed from IDLE
      run_vector(32'd3, 32'd0, 32'd0, 32'd11, 32'd19, 0, 2, 1'b0, st, rd);
      chk("t7_steps", 64'(st), 64'd4);
      chk("t7_reads", 64'(rd), 64'd3);
      // Stray vec_fin in WAIT (ignored) and in SETTLE after MAC (error, no write)
      run_vector(32'd2, 32'd5, 32'd9, 32'd12, 32'hFFFF_FFE9, 0, 0, 1'b1, st, rd);
      chk("t8_seq_err", {63'd0, bus.seq_err}, 64'd1);
      chk("t8_steps", 64'(st), 64'd3);

      repeat (3) tick();
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
